// File: rtl/mul_iter_32_pkg.sv
// Shared definitions for the iterative 32x32 multiplier.
//   WIDTH        operand width (the datapath is written for 32 only)
//   CNT_W        iteration counter width, 2**CNT_W == WIDTH
//   MUL_LATENCY  clocks from the start edge to the cycle done is high
//   state_t      controller state encoding
//   magnitude()  absolute value of an operand, honouring signedness
package mul_iter_32_pkg;

  localparam int WIDTH       = 32;
  localparam int CNT_W       = 5;
  localparam int MUL_LATENCY = 33;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // 0x80000000 maps to itself, which read as unsigned is exactly 2^31.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic             is_signed);
    return (is_signed && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  endfunction

endpackage

// File: rtl/mul_iter_32_if.sv
// Execute-stage <-> multiplier handshake.
//   start      one-cycle request, sampled with is_signed/op_a/op_b
//   is_signed  1 = MULT (two's complement), 0 = MULTU
//   op_a/op_b  multiplicand / multiplier
//   busy       high while an operation is in flight (stall request)
//   done       one-cycle pulse, result valid from here until the next done
//   result_hi  product[63:32] (to HI), result_lo product[31:0] (to LO)
interface mul_iter_32_if;
  import mul_iter_32_pkg::*;

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;

  modport master (
    output start, is_signed, op_a, op_b,
    input  busy, done, result_hi, result_lo
  );

  modport slave (
    input  start, is_signed, op_a, op_b,
    output busy, done, result_hi, result_lo
  );

endinterface

// File: rtl/mul_iter_32_add_32c.sv
// 32-bit carry-lookahead adder with carry-out, made of eight 4-bit
// lookahead blocks. Each block resolves its internal carries from the
// block carry-in; the block group propagate/generate terms then produce
// the carry into the next block.
//   a, b  addends
//   cin   carry in
//   sum   a + b + cin, low 32 bits
//   cout  carry out of bit 31
module mul_iter_32_add_32c
  import mul_iter_32_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NBLK = WIDTH / 4;

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] c;
  logic [NBLK-1:0]  pg;
  logic [NBLK-1:0]  gg;
  logic [NBLK:0]    bc;

  assign p = a ^ b;
  assign g = a & b;

  for (genvar i = 0; i < NBLK; i++) begin : g_blk
    localparam int B = 4 * i;

    assign c[B]   = bc[i];
    assign c[B+1] = g[B] | (p[B] & bc[i]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & bc[i]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & bc[i]);

    assign pg[i] = &p[B+3:B];
    assign gg[i] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                 | (p[B+3] & p[B+2] & p[B+1] & g[B]);
  end

  // Block carries depend only on a, b and cin, never on block sums.
  always_comb begin
    bc[0] = cin;
    for (int i = 0; i < NBLK; i++) begin
      bc[i+1] = gg[i] | (pg[i] & bc[i]);
    end
  end

  assign sum  = p ^ c;
  assign cout = bc[NBLK];

endmodule

// File: rtl/mul_iter_32.sv
// Iterative shift-and-add 32x32 -> 64 multiplier for MULT/MULTU.
// Operands are reduced to magnitudes at start, 32 add/shift steps run
// through the lookahead adder, and the sign is applied in the FIN cycle.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mul_iter_32_if.slave: start/is_signed/op_a/op_b in,
//          busy/done/result_hi/result_lo out
module mul_iter_32
  import mul_iter_32_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  mul_iter_32_if.slave bus
);

  localparam int PW = 2 * WIDTH;

  state_t state;
  state_t state_nxt;

  logic             load;
  logic             step;
  logic             fin;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CNT_W-1:0] cnt;
  logic             neg;

  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             done_q;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    prod;

  // ---------------- controller ----------------
  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block is defaulted first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        // The last step still executes on this edge.
        if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIN;
      end
      FIN: begin
        fin       = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        // A start here is taken exactly as from IDLE.
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  // Add the multiplicand only when the multiplier bit now at acc_lo[0] is set.
  assign addend = acc_lo[0] ? mcand : '0;

  mul_iter_32_add_32c u_add_32c (
    .a    (acc_hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (carry)
  );

  // NOTE: the whole datapath is reset, not just the control state, so an
  // operation aborted by reset leaves nothing behind for the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
    end else if (load) begin
      mcand  <= magnitude(bus.op_a, bus.is_signed);
      acc_hi <= '0;
      acc_lo <= magnitude(bus.op_b, bus.is_signed);
      cnt    <= '0;
      neg    <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
    end else if (step) begin
      // {carry, sum, acc_lo} shifted right by one; consumed multiplier bits
      // fall off the bottom while product bits enter from the top.
      acc_hi <= {carry, sum[WIDTH-1:1]};
      acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
      cnt    <= cnt + CNT_W'(1);
    end
  end

  assign acc  = {acc_hi, acc_lo};
  assign prod = neg ? (~acc + PW'(1)) : acc;

  // Results change only in FIN and hold through IDLE and later runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_hi <= '0;
      res_lo <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= fin;
      if (fin) begin
        res_hi <= prod[PW-1:WIDTH];
        res_lo <= prod[WIDTH-1:0];
      end
    end
  end

  assign bus.busy      = (state == RUN) || (state == FIN);
  assign bus.done      = done_q;
  assign bus.result_hi = res_hi;
  assign bus.result_lo = res_lo;

endmodule

// File: tb/tb_mul_iter_32.sv
// Directed self-checking bench for mul_iter_32: reset values, latency and
// busy width, unsigned/signed products, start-while-busy, reset mid-run
// and back-to-back starts from the DONE cycle.
module tb_mul_iter_32;
  import mul_iter_32_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  mul_iter_32_if bus ();

  mul_iter_32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  // Pulse start for one cycle; returns at the falling edge after the start
  // edge, with the operand inputs scrambled to prove they were captured.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    bus.op_a      = a;
    bus.op_b      = b;
    bus.is_signed = s;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.op_a      = ~a;
    bus.op_b      = ~b;
    bus.is_signed = ~s;
  endtask

  // Counts clocks from the start edge until done, and the cycles with busy.
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = (bus.busy === 1'b1) ? 1 : 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.busy === 1'b1) bcnt++;
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    #1;
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", bus.busy); end
    total++;
    if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", bus.done); end
    total++;
    if (bus.result_hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=00000000", bus.result_hi); end
    total++;
    if (bus.result_lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=00000000", bus.result_lo); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc, bcnt;
    start_op(a, b, s);
    wait_done(cyc, bcnt);
    total++;
    if (cyc !== MUL_LATENCY) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, cyc, MUL_LATENCY); end
    total++;
    if (bcnt !== 33) begin bad++; $display("FAIL %s_busy_cycles got=%0d want=33", name, bcnt); end
    total++;
    if (bus.result_hi !== exp_hi) begin bad++; $display("FAIL %s_hi got=%h want=%h", name, bus.result_hi, exp_hi); end
    total++;
    if (bus.result_lo !== exp_lo) begin bad++; $display("FAIL %s_lo got=%h want=%h", name, bus.result_lo, exp_lo); end
    @(negedge clk);
    total++;
    if (bus.done !== 1'b0) begin bad++; $display("FAIL %s_done_pulse got=%0b want=0", name, bus.done); end
    total++;
    if (bus.result_lo !== exp_lo) begin bad++; $display("FAIL %s_hold_lo got=%h want=%h", name, bus.result_lo, exp_lo); end
  endtask

  task automatic test_start_while_busy();
    int ndone    = 0;
    int done_cyc = -1;
    logic [31:0] lo_at_done = '0;
    logic [31:0] hi_at_done = '0;
    start_op(32'd7, 32'd9, 1'b0);
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ndone++;
        done_cyc   = cyc;
        lo_at_done = bus.result_lo;
        hi_at_done = bus.result_hi;
      end
      bus.start = (cyc == 5 || cyc == 20);
      bus.op_a  = 32'd100;
      bus.op_b  = 32'd100;
    end
    bus.start = 1'b0;
    total++;
    if (ndone !== 1) begin bad++; $display("FAIL busy_start_done_count got=%0d want=1", ndone); end
    total++;
    if (done_cyc !== 33) begin bad++; $display("FAIL busy_start_done_cycle got=%0d want=33", done_cyc); end
    total++;
    if (lo_at_done !== 32'd63) begin bad++; $display("FAIL busy_start_lo got=%0d want=63", lo_at_done); end
    total++;
    if (hi_at_done !== 32'd0) begin bad++; $display("FAIL busy_start_hi got=%h want=00000000", hi_at_done); end
  endtask

  task automatic test_reset_mid_run();
    start_op(32'd11, 32'd13, 1'b0);
    repeat (10) @(negedge clk);
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%0b want=1", bus.busy); end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%0b want=0", bus.busy); end
    total++;
    if (bus.done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%0b want=0", bus.done); end
    total++;
    if (bus.result_hi !== 32'h0) begin bad++; $display("FAIL midrst_hi got=%h want=00000000", bus.result_hi); end
    total++;
    if (bus.result_lo !== 32'h0) begin bad++; $display("FAIL midrst_lo got=%h want=00000000", bus.result_lo); end
    @(negedge clk);
    rst_n = 1'b1;
    test_mul("after_rst", 32'd6, 32'd7, 1'b0, 32'h0, 32'd42);
  endtask

  task automatic test_back_to_back();
    int cyc, bcnt;
    int hold_bad = 0;
    start_op(32'd2, 32'd3, 1'b0);
    wait_done(cyc, bcnt);
    total++;
    if (bus.result_lo !== 32'd6) begin bad++; $display("FAIL b2b_first_lo got=%0d want=6", bus.result_lo); end
    total++;
    if (cyc !== MUL_LATENCY) begin bad++; $display("FAIL b2b_first_latency got=%0d want=%0d", cyc, MUL_LATENCY); end
    // Now in the DONE cycle: issue the next request immediately.
    bus.op_a  = 32'd4;
    bus.op_b  = 32'd5;
    bus.is_signed = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op_a  = 32'hDEAD_BEEF;
    bus.op_b  = 32'h1234_5678;
    total++;
    if (bus.done !== 1'b0) begin bad++; $display("FAIL b2b_done_drop got=%0b want=0", bus.done); end
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%0b want=1", bus.busy); end
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (bus.result_lo !== 32'd6) hold_bad++;
      @(negedge clk);
      cyc++;
    end
    total++;
    if (hold_bad !== 0) begin bad++; $display("FAIL b2b_hold got=%0d_bad_cycles want=0", hold_bad); end
    total++;
    if (cyc !== MUL_LATENCY) begin bad++; $display("FAIL b2b_second_latency got=%0d want=%0d", cyc, MUL_LATENCY); end
    total++;
    if (bus.result_lo !== 32'd20) begin bad++; $display("FAIL b2b_second_lo got=%0d want=20", bus.result_lo); end
    total++;
    if (bus.result_hi !== 32'd0) begin bad++; $display("FAIL b2b_second_hi got=%h want=00000000", bus.result_hi); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mul("u_small",   32'd3,          32'd5,          1'b0, 32'h0000_0000, 32'h0000_000F);
    test_mul("u_max",     32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
    test_mul("s_neg2x3",  32'hFFFF_FFFE,  32'd3,          1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    test_mul("s_m1xm1",   32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 32'h0000_0000, 32'h0000_0001);
    test_mul("s_minxmin", 32'h8000_0000,  32'h8000_0000,  1'b1, 32'h4000_0000, 32'h0000_0000);
    test_mul("s_minx1",   32'h8000_0000,  32'd1,          1'b1, 32'hFFFF_FFFF, 32'h8000_0000);
    test_mul("zero",      32'd0,          32'h1234_5678,  1'b0, 32'h0000_0000, 32'h0000_0000);
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
